// File: rtl/washer_pkg.sv
// Shared washer definitions: program codes, BCD converter state encoding and the
// double-dabble step used by the panel's display converter.
package washer_pkg;

    typedef enum logic [2:0] {
        COLD_WASH   = 3'd0,
        HOT_WASH    = 3'd1,
        RINSING_DRY = 3'd2,
        ONLY_DRY    = 3'd3,
        WARM_WASH   = 3'd4
    } program_e;

    typedef enum logic {
        BCD_IDLE  = 1'b0,
        BCD_SHIFT = 1'b1
    } bcd_state_e;

    typedef struct packed {
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    localparam int unsigned TIMER_W  = 8;
    localparam int unsigned PROG_W   = 3;
    localparam int unsigned BCD_W    = 12;
    localparam int unsigned DD_W     = BCD_W + TIMER_W;
    localparam int unsigned DD_STEPS = TIMER_W;

    function automatic logic [3:0] add3_if_ge5(input logic [3:0] d);
        return (d >= 4'd5) ? 4'(d + 4'd3) : d;
    endfunction

    // One shift/add-3 iteration over {hundreds, tens, ones, binary}.
    function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] s);
        logic [DD_W-1:0] a;
        a = {add3_if_ge5(s[19:16]), add3_if_ge5(s[15:12]), add3_if_ge5(s[11:8]), s[7:0]};
        return {a[DD_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/panel_debounce.sv
// Two-flop synchroniser followed by a stability counter; the output only follows
// the synchronised input after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
module panel_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb = deb_q;

endmodule

// File: rtl/washer_panel.sv
// Front panel of the washer controller: conditions buttons/switches into controller
// inputs and renders controller status. Optional completion buzzer: PANEL_BUZZER_EN.
module washer_panel
    import washer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned BUZZ_CYCLES     = 16,
    parameter int unsigned NUM_PROGRAMS    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_start_raw,
    input  logic               btn_prog_raw,
    input  logic               door_sw_raw,
    input  logic               soap_sw_raw,
    input  logic               lock_door,
    input  logic               program_done,
    input  logic               soap_warning,
    input  logic [TIMER_W-1:0] timer_display,
    output logic               start,
    output logic [PROG_W-1:0]  program_selection,
    output logic               doorclosed,
    output logic               soap,
    output logic [BCD_W-1:0]   disp_bcd,
    output logic               led_soap,
    output logic               door_fault,
    output logic               buzzer
);

    localparam int unsigned ITER_W = $clog2(DD_STEPS);

    logic start_deb, prog_deb, door_deb, soap_deb;

    panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk(clk), .rst(rst), .raw(btn_start_raw), .deb(start_deb)
    );
    panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prog (
        .clk(clk), .rst(rst), .raw(btn_prog_raw), .deb(prog_deb)
    );
    panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_door (
        .clk(clk), .rst(rst), .raw(door_sw_raw), .deb(door_deb)
    );
    panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_soap (
        .clk(clk), .rst(rst), .raw(soap_sw_raw), .deb(soap_deb)
    );

    logic              start_prev_q, start_prev_d;
    logic              prog_prev_q, prog_prev_d;
    logic              start_q, start_d;
    logic [PROG_W-1:0] sel_q, sel_d;
    logic              fault_q, fault_d;
    logic              led_q, led_d;
    logic              start_rise_c, prog_rise_c;

    // Button edges, program stepping, start qualification and door supervision.
    always_comb begin
        start_rise_c = start_deb && !start_prev_q;
        prog_rise_c  = prog_deb && !prog_prev_q;
        start_prev_d = start_deb;
        prog_prev_d  = prog_deb;
        start_d      = start_rise_c && door_deb && !lock_door;
        sel_d        = sel_q;
        if (prog_rise_c && !lock_door) begin
            sel_d = (sel_q == PROG_W'(NUM_PROGRAMS - 1)) ? '0 : sel_q + PROG_W'(1);
        end
        fault_d      = lock_door && (fault_q || !door_deb);
        led_d        = soap_warning;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_prev_q <= 1'b0;
            prog_prev_q  <= 1'b0;
            start_q      <= 1'b0;
            sel_q        <= '0;
            fault_q      <= 1'b0;
            led_q        <= 1'b0;
        end else begin
            start_prev_q <= start_prev_d;
            prog_prev_q  <= prog_prev_d;
            start_q      <= start_d;
            sel_q        <= sel_d;
            fault_q      <= fault_d;
            led_q        <= led_d;
        end
    end

    bcd_state_e         state_q, state_d;
    logic [DD_W-1:0]    shreg_q, shreg_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic [TIMER_W-1:0] last_q, last_d;
    bcd_t               disp_q, disp_d;
    logic [DD_W-1:0]    step_c;

    // Binary-to-BCD converter; the display only changes when a full conversion completes.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        iter_d  = iter_q;
        last_d  = last_q;
        disp_d  = disp_q;
        step_c  = dd_step(shreg_q);
        case (state_q)
            BCD_IDLE: begin
                if (timer_display != last_q) begin
                    last_d  = timer_display;
                    shreg_d = {BCD_W'(0), timer_display};
                    iter_d  = '0;
                    state_d = BCD_SHIFT;
                end
            end
            BCD_SHIFT: begin
                shreg_d = step_c;
                iter_d  = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(DD_STEPS - 1)) begin
                    disp_d  = step_c[DD_W-1:TIMER_W];
                    state_d = BCD_IDLE;
                end
            end
            default: state_d = BCD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BCD_IDLE;
            shreg_q <= '0;
            iter_q  <= '0;
            last_q  <= '0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            iter_q  <= iter_d;
            last_q  <= last_d;
            disp_q  <= disp_d;
        end
    end

`ifdef PANEL_BUZZER_EN
    localparam int unsigned BUZZ_W = $clog2(BUZZ_CYCLES + 1);

    logic [BUZZ_W-1:0] buzz_cnt_q, buzz_cnt_d;
    logic              done_prev_q, done_prev_d;
    logic              buzzer_q, buzzer_d;

    // A fresh completion edge reloads the full on-time, even mid-buzz.
    always_comb begin
        done_prev_d = program_done;
        buzz_cnt_d  = buzz_cnt_q;
        if (program_done && !done_prev_q) begin
            buzz_cnt_d = BUZZ_W'(BUZZ_CYCLES);
        end else if (buzz_cnt_q != '0) begin
            buzz_cnt_d = buzz_cnt_q - BUZZ_W'(1);
        end
        buzzer_d    = (buzz_cnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buzz_cnt_q  <= '0;
            done_prev_q <= 1'b0;
            buzzer_q    <= 1'b0;
        end else begin
            buzz_cnt_q  <= buzz_cnt_d;
            done_prev_q <= done_prev_d;
            buzzer_q    <= buzzer_d;
        end
    end

    assign buzzer = buzzer_q;
`else
    logic unused_buzz;
    assign unused_buzz = program_done | (BUZZ_CYCLES == 0);
    assign buzzer      = 1'b0;
`endif

    assign start             = start_q;
    assign program_selection = sel_q;
    assign doorclosed        = door_deb;
    assign soap              = soap_deb;
    assign disp_bcd          = disp_q;
    assign led_soap          = led_q;
    assign door_fault        = fault_q;

endmodule
